hmc_batch_proc: RTL and testbench
=================================

HMC_BATCH_PROC -- requirements
Module: hmc_batch_proc

Interface
REQ-001 Parameter TAG_WIDTH, default 6: width of the HMC tag field.
REQ-002 Parameter SIZE_WIDTH, default 4: width of the HMC size field.
REQ-003 Parameter ADDR_WIDTH, default 34: width of the HMC byte address.
REQ-004 Parameter DATA_WIDTH, default 128: flit width; one flit equals 16 address bytes.
REQ-005 Parameter BATCH, default 32: flits per batch; power of two, 2..2^TAG_WIDTH.
REQ-006 One clock; reset is asynchronous and active-low. Ports below: name  direction  width  meaning.
REQ-007 rx_clk  in  1  sole clock; rst_n  in  1  asynchronous active-low reset.
REQ-008 enable  in  1  start request; src_addr, dst_addr  in  ADDR_WIDTH  byte bases; work_size  in  32  flit count.
REQ-009 op_mode  in  2  00 pass, 01 bitwise invert, 10 XOR with op_key, 11 treated as 00; op_key  in  DATA_WIDTH.
REQ-010 cmd_valid out 1, cmd_ready in 1, cmd out 4, addr out ADDR_WIDTH, size out SIZE_WIDTH, tag out TAG_WIDTH: command channel.
REQ-011 wr_data out DATA_WIDTH, wr_data_valid out 1, wr_data_ready in 1: write-data channel.
REQ-012 rd_data in DATA_WIDTH, rd_data_tag in TAG_WIDTH, rd_data_valid in 1, errstat in 7, dinv in 1: response channel.
REQ-013 busy out 1, finished out 1, err_count out 7, dinv_count out 7, bad_tag_count out 7: status outputs.

Function
REQ-014 States are IDLE, READ, WAIT, WRITE and DONE.
REQ-015 IDLE to READ on the cycle enable=1, when work_size!=0:
- src_addr, dst_addr, work_size, op_mode and op_key are latched.
- All counters except the status counters are cleared.
REQ-016 IDLE with enable=1 and work_size=0 goes directly to DONE.
REQ-017 Batch length n = min(BATCH, remaining flits).
- READ issues n reads with tags 0..n-1 in order.
- Each read uses cmd=HMC_CMD_RD, size=1, addr=src+16*k, where k is the global flit index.
- Address arithmetic is modulo 2^ADDR_WIDTH.
REQ-018 Command handshake:
- cmd_valid, once raised, holds until the cycle with cmd_valid&&cmd_ready.
- cmd, addr, size and tag stay stable for that whole interval.
- A transfer occurs only in that cycle; the next command may be presented in the following cycle.
REQ-019 READ to WAIT when the nth read transfers.
REQ-020 A response with rd_data_valid=1 and rd_data_tag<n, whose tag has not yet arrived in this batch:
- rd_data is stored in the buffer entry for that tag.
- The tag is marked received.
REQ-021 Responses are accepted in any order and in any state from READ through WAIT, including while reads are still being issued.
REQ-022 A response with rd_data_tag>=n, or a duplicate tag, or arriving in IDLE/WRITE/DONE:
- is discarded;
- increments bad_tag_count, saturating at 127.
REQ-023 Each rd_data_valid with errstat!=0 increments err_count, saturating at 127; each rd_data_valid with dinv=1 increments dinv_count, saturating at 127.
REQ-024 WAIT to WRITE in the cycle after all n tags have been received.
REQ-025 WRITE issues n writes in tag order: cmd=HMC_CMD_WR, size=1, addr=dst+16*k, wr_data=f(buffer[tag]), where f is selected by op_mode.
REQ-026 For each write, cmd_valid and wr_data_valid assert together.
- Each channel deasserts independently after its own handshake.
- The next write starts only after both channels have transferred.
REQ-027 When the nth write completes:
- remaining flits > 0 goes to READ with tag 0 and the next addresses;
- otherwise goes to DONE.
REQ-028 busy=1 in READ, WAIT and WRITE; busy=0 otherwise.
REQ-029 finished=1 only in DONE. DONE returns to IDLE on the cycle enable=0.
REQ-030 enable deassertion in READ, WAIT or WRITE is ignored; the job runs to completion.
REQ-031 If a response and a bad-tag event happen in the same cycle, both counters update.
REQ-032 err_count, dinv_count and bad_tag_count clear only on reset, not at job start.

Reset
REQ-033 On rst_n=0, asynchronously:
- state goes to IDLE;
- cmd_valid, wr_data_valid, busy and finished go to 0;
- cmd, addr, size, tag and wr_data go to 0;
- all counters and received flags go to 0.
Buffer contents are undefined after reset.
REQ-034 Reset asserted mid-job abandons the job; outstanding responses after release arrive in IDLE and count as bad tags.

Verification
REQ-035 work_size=40, BATCH=32, op_mode=01, in-order responses, ready always high:
- 32 reads, 32 writes, 8 reads, 8 writes;
- write addr = dst+16*k, data = ~src data;
- finished=1.
REQ-036 Responses for batch of 8 returned in reverse tag order with op_mode=10:
- writes occur in tag order 0..7;
- each data = rd_data^op_key for the matching tag.
REQ-037 cmd_ready random at 50%, wr_data_ready low for 5 cycles after each cmd accept:
- no command or data is lost or duplicated;
- fields stay stable while valid is held.
REQ-038 Duplicate tag 3 and out-of-range tag 40 injected during a batch of 8:
- bad_tag_count=2;
- stored data for tag 3 equals the first response.
REQ-039 work_size=0 -> finished=1 in the cycle after enable, with no commands issued.
REQ-040 rst_n pulsed low during WAIT -> all outputs 0 immediately; a later job with work_size=4 completes correctly.

Source files
------------

// File: rtl/hmc_batch_proc.sv
// hmc_batch_proc
//   Moves work_size 16-byte flits from src_addr to dst_addr over an HMC-style
//   command/data interface, in batches of up to BATCH flits. Each batch is read
//   into a local buffer (tags 0..n-1, responses in any order), then written back
//   in tag order through a per-flit transform picked by op_mode.
// Ports
//   rx_clk, rst_n                      clock, async active-low reset
//   enable, src_addr, dst_addr,
//   work_size, op_mode, op_key         job request (latched at start)
//   cmd_valid/ready, cmd, addr,
//   size, tag                          command channel
//   wr_data, wr_data_valid/ready       write-data channel
//   rd_data, rd_data_tag,
//   rd_data_valid, errstat, dinv       read-response channel
//   busy, finished, err_count,
//   dinv_count, bad_tag_count          status
module hmc_batch_proc #(
  parameter int TAG_WIDTH  = 6,
  parameter int SIZE_WIDTH = 4,
  parameter int ADDR_WIDTH = 34,
  parameter int DATA_WIDTH = 128,
  parameter int BATCH      = 32,
  parameter logic [3:0] HMC_CMD_RD = 4'h1,
  parameter logic [3:0] HMC_CMD_WR = 4'h2
) (
  input  logic                  rx_clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [31:0]           work_size,
  input  logic [1:0]            op_mode,
  input  logic [DATA_WIDTH-1:0] op_key,
  output logic                  cmd_valid,
  input  logic                  cmd_ready,
  output logic [3:0]            cmd,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [SIZE_WIDTH-1:0] size,
  output logic [TAG_WIDTH-1:0]  tag,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_data_valid,
  input  logic                  wr_data_ready,
  input  logic [DATA_WIDTH-1:0] rd_data,
  input  logic [TAG_WIDTH-1:0]  rd_data_tag,
  input  logic                  rd_data_valid,
  input  logic [6:0]            errstat,
  input  logic                  dinv,
  output logic                  busy,
  output logic                  finished,
  output logic [6:0]            err_count,
  output logic [6:0]            dinv_count,
  output logic [6:0]            bad_tag_count
);
  localparam int IW = $clog2(BATCH);
  localparam int NW = IW + 1;

  typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, DONE} state_t;
  state_t state, state_nx;

  logic [NW-1:0]         n, rd_cnt, wr_cnt;
  logic [31:0]           left;            // flits not yet assigned to a batch
  logic [ADDR_WIDTH-1:0] rd_ptr, wr_ptr;
  logic [1:0]            mode;
  logic [DATA_WIDTH-1:0] key;
  logic [BATCH-1:0]      recv, batch_mask;
  logic [DATA_WIDTH-1:0] buffer [BATCH];

  function automatic logic [NW-1:0] batch_len(input logic [31:0] rem);
    return (rem >= 32'(BATCH)) ? NW'(BATCH) : NW'(rem);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] xform(input logic [1:0] m,
                                                  input logic [DATA_WIDTH-1:0] d,
                                                  input logic [DATA_WIDTH-1:0] k);
    case (m)
      2'b01:   return ~d;
      2'b10:   return d ^ k;
      default: return d;
    endcase
  endfunction

  logic          job_start, c_done, d_done, rd_issue, rd_last, wr_issue, wr_last;
  logic          all_recv, tag_ok, resp_ok, resp_bad;
  logic [IW-1:0] tag_idx;

  always_comb begin
    for (int i = 0; i < BATCH; i++) batch_mask[i] = (i < int'(n));
  end

  assign all_recv  = &(recv | ~batch_mask);
  assign job_start = (state == IDLE) && enable && (work_size != 32'd0);
  // a channel is "done" when nothing is pending on it or it hands off this cycle
  assign c_done    = !cmd_valid || cmd_ready;
  assign d_done    = !wr_data_valid || wr_data_ready;
  assign rd_issue  = (state == READ) && c_done && (rd_cnt < n);
  assign rd_last   = (state == READ) && cmd_valid && cmd_ready && (rd_cnt == n);
  assign wr_issue  = (state == WRITE) && c_done && d_done && (wr_cnt < n);
  assign wr_last   = (state == WRITE) && c_done && d_done && (wr_cnt == n);

  // range test on the full tag first, so the truncated index never aliases
  assign tag_idx  = rd_data_tag[IW-1:0];
  assign tag_ok   = 32'(rd_data_tag) < 32'(n);
  assign resp_ok  = rd_data_valid && ((state == READ) || (state == WAIT)) &&
                    tag_ok && !recv[tag_idx];
  assign resp_bad = rd_data_valid && !resp_ok;

  always_ff @(posedge rx_clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    finished = 1'b0;
    case (state)
      IDLE:  if (enable) state_nx = (work_size == 32'd0) ? DONE : READ;
      READ:  begin busy = 1'b1; if (rd_last) state_nx = WAIT; end
      WAIT:  begin busy = 1'b1; if (all_recv) state_nx = WRITE; end
      WRITE: begin
        busy = 1'b1;
        if (wr_last) state_nx = (left != 32'd0) ? READ : DONE;
      end
      DONE:  begin finished = 1'b1; if (!enable) state_nx = IDLE; end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_valid     <= 1'b0;
      wr_data_valid <= 1'b0;
      cmd           <= '0;
      addr          <= '0;
      size          <= '0;
      tag           <= '0;
      wr_data       <= '0;
      n             <= '0;
      rd_cnt        <= '0;
      wr_cnt        <= '0;
      left          <= '0;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      mode          <= '0;
      key           <= '0;
      recv          <= '0;
    end else begin
      if (job_start) begin
        rd_ptr <= src_addr;
        wr_ptr <= dst_addr;
        mode   <= op_mode;
        key    <= op_key;
        n      <= batch_len(work_size);
        left   <= work_size - 32'(batch_len(work_size));
        rd_cnt <= '0;
        wr_cnt <= '0;
        recv   <= '0;
      end

      if (resp_ok) recv[tag_idx] <= 1'b1;

      // reads: load the next command on the same edge the previous one hands off
      if (state == READ) begin
        if (rd_issue) begin
          cmd_valid <= 1'b1;
          cmd       <= HMC_CMD_RD;
          addr      <= rd_ptr;
          size      <= SIZE_WIDTH'(1);
          tag       <= TAG_WIDTH'(rd_cnt);
          rd_ptr    <= rd_ptr + ADDR_WIDTH'(16);
          rd_cnt    <= rd_cnt + NW'(1);
        end else if (cmd_valid && cmd_ready) begin
          cmd_valid <= 1'b0;
        end
      end

      // writes: both channels launch together, retire independently
      if (state == WRITE) begin
        if (wr_issue) begin
          cmd_valid     <= 1'b1;
          wr_data_valid <= 1'b1;
          cmd           <= HMC_CMD_WR;
          addr          <= wr_ptr;
          size          <= SIZE_WIDTH'(1);
          tag           <= TAG_WIDTH'(wr_cnt);
          wr_data       <= xform(mode, buffer[wr_cnt[IW-1:0]], key);
          wr_ptr        <= wr_ptr + ADDR_WIDTH'(16);
          wr_cnt        <= wr_cnt + NW'(1);
        end else begin
          if (cmd_valid && cmd_ready)         cmd_valid     <= 1'b0;
          if (wr_data_valid && wr_data_ready) wr_data_valid <= 1'b0;
        end
        if (wr_last && (left != 32'd0)) begin
          n      <= batch_len(left);
          left   <= left - 32'(batch_len(left));
          rd_cnt <= '0;
          wr_cnt <= '0;
          recv   <= '0;
        end
      end
    end
  end

  // batch buffer holds payload only; validity lives in recv
  always_ff @(posedge rx_clk) begin
    if (resp_ok) buffer[tag_idx] <= rd_data;
  end

  always_ff @(posedge rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count     <= '0;
      dinv_count    <= '0;
      bad_tag_count <= '0;
    end else begin
      if (rd_data_valid && (errstat != 7'd0) && (err_count != 7'd127))
        err_count <= err_count + 7'd1;
      if (rd_data_valid && dinv && (dinv_count != 7'd127))
        dinv_count <= dinv_count + 7'd1;
      if (resp_bad && (bad_tag_count != 7'd127))
        bad_tag_count <= bad_tag_count + 7'd1;
    end
  end

endmodule

// File: tb/tb_hmc_batch_proc.sv
// Testbench for hmc_batch_proc: table of copy jobs checked through a
// scoreboard (expected reads/writes queued at job start, popped on each
// handshake), a behavioural memory responder, and hand-written sequences for
// duplicate/out-of-range tags, zero-length jobs and mid-job reset.
module tb_hmc_batch_proc;
  localparam int TAG_W = 6, SIZE_W = 4, ADDR_W = 34, DATA_W = 128, BATCH = 32;
  localparam logic [3:0] CMD_RD = 4'h1, CMD_WR = 4'h2;

  logic              rx_clk = 1'b0, rst_n = 1'b1, enable = 1'b0;
  logic [ADDR_W-1:0] src_addr = '0, dst_addr = '0;
  logic [31:0]       work_size = '0;
  logic [1:0]        op_mode = '0;
  logic [DATA_W-1:0] op_key = '0;
  logic              cmd_valid, cmd_ready = 1'b1;
  logic [3:0]        cmd;
  logic [ADDR_W-1:0] addr;
  logic [SIZE_W-1:0] size;
  logic [TAG_W-1:0]  tag;
  logic [DATA_W-1:0] wr_data;
  logic              wr_data_valid, wr_data_ready = 1'b1;
  logic [DATA_W-1:0] rd_data = '0;
  logic [TAG_W-1:0]  rd_data_tag = '0;
  logic              rd_data_valid = 1'b0;
  logic [6:0]        errstat = '0;
  logic              dinv = 1'b0;
  logic              busy, finished;
  logic [6:0]        err_count, dinv_count, bad_tag_count;

  hmc_batch_proc #(.TAG_WIDTH(TAG_W), .SIZE_WIDTH(SIZE_W), .ADDR_WIDTH(ADDR_W),
                   .DATA_WIDTH(DATA_W), .BATCH(BATCH),
                   .HMC_CMD_RD(CMD_RD), .HMC_CMD_WR(CMD_WR)) dut (
    .rx_clk(rx_clk), .rst_n(rst_n), .enable(enable), .src_addr(src_addr),
    .dst_addr(dst_addr), .work_size(work_size), .op_mode(op_mode), .op_key(op_key),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd(cmd), .addr(addr),
    .size(size), .tag(tag), .wr_data(wr_data), .wr_data_valid(wr_data_valid),
    .wr_data_ready(wr_data_ready), .rd_data(rd_data), .rd_data_tag(rd_data_tag),
    .rd_data_valid(rd_data_valid), .errstat(errstat), .dinv(dinv), .busy(busy),
    .finished(finished), .err_count(err_count), .dinv_count(dinv_count),
    .bad_tag_count(bad_tag_count));

  always #5 rx_clk = ~rx_clk;

  typedef struct { logic [ADDR_W-1:0] addr; logic [TAG_W-1:0] tag; } cmd_t;
  typedef struct { logic [TAG_W-1:0] tag; logic [DATA_W-1:0] data; } inj_t;
  typedef struct {
    int ws; logic [1:0] mode; logic [ADDR_W-1:0] src, dst;
    bit rnd; int rsp; bit err; int exp_bad;
  } vec_t;

  cmd_t              rd_q[$], wc_q[$], pending[$];
  logic [DATA_W-1:0] wd_q[$];
  inj_t              inj[$];

  int n_chk = 0, n_fail = 0, n_rd = 0, n_cmd = 0;
  int exp_err = 0, exp_dinv = 0, exp_bad = 0;
  int rsp_mode = 1, quiet = 0, hold = 0;
  bit rnd_ready = 0, err_inj = 0, rd_seen = 0, cmd_acc = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: handshake with no expected entry (addr %0h tag %0h)", name, addr, tag);
  endtask

  function automatic logic [DATA_W-1:0] mem_data(input logic [ADDR_W-1:0] a);
    logic [31:0] l;
    l = a[31:0] ^ {30'd0, a[ADDR_W-1:32]};
    return {l ^ 32'hDEADBEEF, l + 32'h01234567, ~l, l * 32'h9E3779B1};
  endfunction

  function automatic logic [DATA_W-1:0] xf(input logic [1:0] m, input logic [DATA_W-1:0] k,
                                           input logic [DATA_W-1:0] d);
    if (m == 2'b01) return ~d;
    if (m == 2'b10) return d ^ k;
    return d;
  endfunction

  // ready generation: random cmd_ready, wr_data_ready held off 5 cycles per cmd accept
  initial forever begin
    @(posedge rx_clk); #1;
    if (rnd_ready) begin
      cmd_ready = 1'($urandom_range(0, 1));
      if (cmd_acc) hold = 5;
      cmd_acc = 0;
      wr_data_ready = (hold == 0);
      if (hold > 0) hold--;
    end else begin
      cmd_ready = 1'b1;
      wr_data_ready = 1'b1;
      cmd_acc = 0;
    end
  end

  // memory responder: injected responses first, then in-order or reverse-after-quiet
  initial forever begin
    cmd_t p;
    inj_t ij;
    @(posedge rx_clk); #1;
    rd_data_valid = 1'b0;
    errstat = '0;
    dinv = 1'b0;
    if (rd_seen) quiet = 0; else if (quiet < 100) quiet++;
    rd_seen = 0;
    if (inj.size() > 0) begin
      ij = inj.pop_front();
      rd_data_valid = 1'b1;
      rd_data_tag = ij.tag;
      rd_data = ij.data;
    end else if (pending.size() > 0 && (rsp_mode == 1 || (rsp_mode == 2 && quiet >= 2))) begin
      if (rsp_mode == 1) p = pending.pop_front();
      else               p = pending.pop_back();
      rd_data_valid = 1'b1;
      rd_data_tag = p.tag;
      rd_data = mem_data(p.addr);
      if (err_inj && p.tag == TAG_W'(1)) begin
        errstat = 7'h05;
        if (exp_err < 127) exp_err++;
      end
      if (err_inj && p.tag == TAG_W'(2)) begin
        dinv = 1'b1;
        if (exp_dinv < 127) exp_dinv++;
      end
    end
  end

  // handshake monitor / scoreboard
  logic              hold_c = 0, hold_d = 0;
  logic [3:0]        pc;
  logic [ADDR_W-1:0] pa;
  logic [TAG_W-1:0]  pt;
  logic [SIZE_W-1:0] ps;
  logic [DATA_W-1:0] pd;
  always @(negedge rx_clk) begin
    cmd_t e;
    logic [DATA_W-1:0] d;
    if (hold_c) begin
      chk("cmd_valid_held", 128'(cmd_valid), 128'(1));
      chk("cmd_fields_stable", 128'({cmd, addr, tag, size}), 128'({pc, pa, pt, ps}));
    end
    if (hold_d) begin
      chk("wr_valid_held", 128'(wr_data_valid), 128'(1));
      chk("wr_data_stable", wr_data, pd);
    end
    if (cmd_valid && cmd_ready) begin
      n_cmd++;
      cmd_acc = 1;
      if (cmd == CMD_RD) begin
        n_rd++;
        rd_seen = 1;
        pending.push_back('{addr: addr, tag: tag});
        if (rd_q.size() == 0) fail_now("rd_unexpected");
        else begin
          e = rd_q.pop_front();
          chk("rd_addr", 128'(addr), 128'(e.addr));
          chk("rd_tag", 128'(tag), 128'(e.tag));
          chk("rd_size", 128'(size), 128'(1));
        end
      end else if (cmd == CMD_WR) begin
        if (wc_q.size() == 0) fail_now("wr_unexpected");
        else begin
          e = wc_q.pop_front();
          chk("wr_addr", 128'(addr), 128'(e.addr));
          chk("wr_tag", 128'(tag), 128'(e.tag));
          chk("wr_size", 128'(size), 128'(1));
        end
      end else chk("cmd_code", 128'(cmd), 128'(CMD_WR));
    end
    if (wr_data_valid && wr_data_ready) begin
      if (wd_q.size() == 0) fail_now("wdata_unexpected");
      else begin
        d = wd_q.pop_front();
        chk("wr_data", wr_data, d);
      end
    end
    hold_c = cmd_valid && !cmd_ready;
    hold_d = wr_data_valid && !wr_data_ready;
    pc = cmd; pa = addr; pt = tag; ps = size; pd = wr_data;
  end

  task automatic start_job(input int ws, input logic [1:0] md, input logic [ADDR_W-1:0] s,
                           input logic [ADDR_W-1:0] d, input logic [DATA_W-1:0] k);
    for (int i = 0; i < ws; i++) begin
      logic [ADDR_W-1:0] sa, da;
      sa = s + ADDR_W'(16 * i);
      da = d + ADDR_W'(16 * i);
      rd_q.push_back('{addr: sa, tag: TAG_W'(i % BATCH)});
      wc_q.push_back('{addr: da, tag: TAG_W'(i % BATCH)});
      wd_q.push_back(xf(md, k, mem_data(sa)));
    end
    @(posedge rx_clk); #1;
    enable = 1'b1; work_size = 32'(ws); src_addr = s; dst_addr = d; op_mode = md; op_key = k;
    @(posedge rx_clk); #1;
    // drop enable and scramble the request: the job must run from latched values
    enable = 1'b0; work_size = $urandom; op_mode = 2'($urandom_range(0, 3));
    src_addr = ADDR_W'({$urandom, $urandom}); dst_addr = ADDR_W'({$urandom, $urandom});
    op_key = {$urandom, $urandom, $urandom, $urandom};
    if (ws != 0) begin
      @(negedge rx_clk);
      chk("busy_after_start", 128'(busy), 128'(1));
    end
  endtask

  task automatic finish_job(input string nm, input int ws, input int rd0);
    int cyc = 0;
    while (finished !== 1'b1 && cyc < 6000) begin @(negedge rx_clk); cyc++; end
    chk({nm, "_finished"}, 128'(finished), 128'(1));
    chk({nm, "_busy_done"}, 128'(busy), 128'(0));
    chk({nm, "_reads"}, 128'(n_rd - rd0), 128'(ws));
    chk({nm, "_queues_empty"}, 128'(rd_q.size() + wc_q.size() + wd_q.size()), 128'(0));
    chk({nm, "_bad_tag_count"}, 128'(bad_tag_count), 128'(exp_bad));
    chk({nm, "_err_count"}, 128'(err_count), 128'(exp_err));
    chk({nm, "_dinv_count"}, 128'(dinv_count), 128'(exp_dinv));
    @(negedge rx_clk); @(negedge rx_clk);
    chk({nm, "_back_to_idle"}, 128'(finished), 128'(0));
  endtask

  task automatic wait_pend(input string nm, input int cnt);
    int cyc = 0;
    while (pending.size() < cnt && cyc < 500) begin @(negedge rx_clk); cyc++; end
    chk({nm, "_reads_issued"}, 128'(pending.size()), 128'(cnt));
  endtask

  vec_t vecs[6];

  initial begin
    int rd0, c0;
    logic [ADDR_W-1:0] a3;

    // ---- reset state ----
    #1 rst_n = 1'b0;
    #2;
    chk("rst_cmd_valid", 128'(cmd_valid), 128'(0));
    chk("rst_wr_data_valid", 128'(wr_data_valid), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_finished", 128'(finished), 128'(0));
    chk("rst_cmd_fields", 128'({cmd, addr, size, tag}), 128'(0));
    chk("rst_wr_data", wr_data, 128'(0));
    chk("rst_counters", 128'({err_count, dinv_count, bad_tag_count}), 128'(0));
    repeat (2) @(posedge rx_clk);
    #1 rst_n = 1'b1;

    // ---- table-driven jobs ----
    //          ws  mode   src              dst              rnd rsp err bad
    vecs[0] = '{40, 2'b01, 34'h0_0000_1000, 34'h1_0000_0000, 0,  1,  0,  0};
    vecs[1] = '{ 8, 2'b10, 34'h0_2000_0000, 34'h0_3000_0000, 0,  2,  0,  0};
    vecs[2] = '{20, 2'b10, 34'h0_0004_0000, 34'h0_0008_0000, 1,  1,  1,  0};
    vecs[3] = '{ 3, 2'b00, 34'h3_FFFF_FFE0, 34'h0_0000_0100, 1,  1,  0,  0};
    vecs[4] = '{33, 2'b11, 34'h0_1234_5670, 34'h3_FFFF_FF00, 0,  1,  1,  0};
    vecs[5] = '{64, 2'b01, 34'h2_0000_0000, 34'h2_8000_0000, 0,  2,  0,  0};
    foreach (vecs[i]) begin
      rnd_ready = vecs[i].rnd;
      rsp_mode  = vecs[i].rsp;
      err_inj   = vecs[i].err;
      exp_bad  += vecs[i].exp_bad;
      rd0 = n_rd;
      start_job(vecs[i].ws, vecs[i].mode, vecs[i].src, vecs[i].dst,
                {$urandom, $urandom, $urandom, $urandom});
      finish_job($sformatf("vec%0d", i), vecs[i].ws, rd0);
    end
    rnd_ready = 0;
    err_inj = 0;

    // ---- duplicate tag 3 and out-of-range tag 40 in a batch of 8 ----
    rsp_mode = 0;
    rd0 = n_rd;
    start_job(8, 2'b01, 34'h0_0050_0000, 34'h0_0060_0000, '0);
    wait_pend("dup", 8);
    a3 = '0;
    foreach (pending[i]) if (pending[i].tag == TAG_W'(3)) a3 = pending[i].addr;
    inj.push_back('{tag: TAG_W'(3), data: mem_data(a3)});
    inj.push_back('{tag: TAG_W'(3), data: ~mem_data(a3) ^ 128'h5});
    inj.push_back('{tag: TAG_W'(40), data: 128'h1234});
    foreach (pending[i])
      if (pending[i].tag != TAG_W'(3)) inj.push_back('{tag: pending[i].tag, data: mem_data(pending[i].addr)});
    pending.delete();
    exp_bad += 2;
    finish_job("dup", 8, rd0);

    // ---- zero-length job: finished the cycle after enable, no commands ----
    c0 = n_cmd;
    @(posedge rx_clk); #1;
    enable = 1'b1; work_size = 32'd0;
    @(negedge rx_clk);
    chk("ws0_not_yet_finished", 128'(finished), 128'(0));
    @(posedge rx_clk); #1;
    enable = 1'b0;
    @(negedge rx_clk);
    chk("ws0_finished", 128'(finished), 128'(1));
    chk("ws0_busy", 128'(busy), 128'(0));
    @(negedge rx_clk);
    chk("ws0_back_to_idle", 128'(finished), 128'(0));
    chk("ws0_no_commands", 128'(n_cmd - c0), 128'(0));

    // ---- reset during WAIT, stale responses land in IDLE ----
    rsp_mode = 0;
    start_job(4, 2'b00, 34'h0_0070_0000, 34'h0_0080_0000, '0);
    wait_pend("rstw", 4);
    @(negedge rx_clk); @(negedge rx_clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rstw_cmd_valid", 128'(cmd_valid), 128'(0));
    chk("rstw_wr_data_valid", 128'(wr_data_valid), 128'(0));
    chk("rstw_busy", 128'(busy), 128'(0));
    chk("rstw_finished", 128'(finished), 128'(0));
    chk("rstw_cmd_fields", 128'({cmd, addr, size, tag}), 128'(0));
    chk("rstw_wr_data", wr_data, 128'(0));
    chk("rstw_counters", 128'({err_count, dinv_count, bad_tag_count}), 128'(0));
    rd_q.delete(); wc_q.delete(); wd_q.delete();
    exp_err = 0; exp_dinv = 0; exp_bad = 0;
    @(posedge rx_clk); #1 rst_n = 1'b1;
    foreach (pending[i]) inj.push_back('{tag: pending[i].tag, data: mem_data(pending[i].addr)});
    exp_bad = pending.size();
    pending.delete();
    repeat (8) @(negedge rx_clk);
    chk("rstw_stale_bad_tags", 128'(bad_tag_count), 128'(exp_bad));
    rsp_mode = 1;
    rd0 = n_rd;
    start_job(4, 2'b10, 34'h0_0090_0000, 34'h0_00A0_0000, {4{32'hC3C3_5A5A}});
    finish_job("after_rst", 4, rd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
